// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, one quotient bit per clock.
// Ports: clk, rst (async high); in_vld/in_rdy with A, B, sgn operands;
//   out_vld/out_rdy with Q, R, dz (divide by zero), ovf (MIN / -1).
module div_iter #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic            sgn,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [BITS-1:0] Q,
  output logic [BITS-1:0] R,
  output logic            dz,
  output logic            ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FIX,
    DONE
  } state_t;

  localparam int IW = $clog2(BITS) + 1;
  localparam logic [BITS-1:0] L_ONE = BITS'(1);
  localparam logic [BITS-1:0] L_ALL = '1;
  localparam logic [BITS-1:0] L_MIN = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [IW-1:0]   L_TOP = IW'(BITS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [BITS-1:0]   r_q;
  logic [BITS-1:0]   r_rem;
  logic [BITS-1:0]   r_bmag;
  logic [IW-1:0]     r_idx;
  logic              r_qneg;
  logic              r_rneg;
  logic              r_dz;
  logic              r_ovf;

  logic              w_dz;
  logic              w_ovf;
  logic [BITS-1:0]   w_amag;
  logic [BITS-1:0]   w_bmag;
  logic [2*BITS-1:0] w_shift;
  logic              w_ge;
  logic [BITS-1:0]   w_diff;
  logic [BITS-1:0]   w_qbit;
  logic              w_last;

  assign w_dz  = (B == '0);
  assign w_ovf = sgn & (A == L_MIN) & (B == L_ALL);

  // |MIN| wraps to MIN, which is the correct unsigned magnitude.
  assign w_amag = (sgn & A[BITS-1]) ? (~A + L_ONE) : A;
  assign w_bmag = (sgn & B[BITS-1]) ? (~B + L_ONE) : B;

  // Divisor shifted into double width so no bits fall off the top.
  assign w_shift = {{BITS{1'b0}}, r_bmag} << r_idx;
  assign w_ge    = ({{BITS{1'b0}}, r_rem} >= w_shift);
  assign w_diff  = r_rem - w_shift[BITS-1:0];
  assign w_qbit  = L_ONE << r_idx;
  assign w_last  = (r_idx == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (in_vld) begin
          w_next = (w_dz | w_ovf) ? DONE : ACTIVE;
        end
      end
      ACTIVE: begin
        if (w_last) begin
          w_next = FIX;
        end
      end
      FIX: begin
        w_next = DONE;
      end
      DONE: begin
        if (out_rdy) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      r_rem  <= '0;
      r_bmag <= '0;
      r_idx  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_vld) begin
            r_dz  <= w_dz;
            r_ovf <= w_ovf & ~w_dz;
            if (w_dz) begin
              r_q    <= L_ALL;
              r_rem  <= A;
              r_qneg <= 1'b0;
              r_rneg <= 1'b0;
            end else if (w_ovf) begin
              r_q    <= A;
              r_rem  <= '0;
              r_qneg <= 1'b0;
              r_rneg <= 1'b0;
            end else begin
              r_q    <= '0;
              r_rem  <= w_amag;
              r_bmag <= w_bmag;
              r_idx  <= L_TOP;
              r_qneg <= sgn & (A[BITS-1] ^ B[BITS-1]);
              r_rneg <= sgn & A[BITS-1];
            end
          end
        end
        ACTIVE: begin
          if (w_ge) begin
            r_rem <= w_diff;
            r_q   <= r_q | w_qbit;
          end
          if (!w_last) begin
            r_idx <= r_idx - IW'(1);
          end
        end
        FIX: begin
          if (r_qneg) begin
            r_q <= ~r_q + L_ONE;
          end
          if (r_rneg) begin
            r_rem <= ~r_rem + L_ONE;
          end
          r_qneg <= 1'b0;
          r_rneg <= 1'b0;
        end
        DONE: begin
          if (out_rdy) begin
            r_dz  <= 1'b0;
            r_ovf <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_rdy  = (r_state == IDLE);
  assign out_vld = (r_state == DONE);
  assign Q       = r_q;
  assign R       = r_rem;
  assign dz      = r_dz;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: randomized and directed checks of div_iter at
// BITS=8 and BITS=32 against an integer-arithmetic reference.
module tb_div_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       v8 = 1'b0;
  logic       rdy8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       s8 = 1'b0;
  logic       ov8;
  logic       ordy8 = 1'b0;
  logic [7:0] q8;
  logic [7:0] rr8;
  logic       dz8;
  logic       of8;

  logic        v32 = 1'b0;
  logic        rdy32;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        s32 = 1'b0;
  logic        ov32;
  logic        ordy32 = 1'b0;
  logic [31:0] q32;
  logic [31:0] rr32;
  logic        dz32;
  logic        of32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_iter #(.BITS(8)) u_d8 (
    .clk(clk), .rst(rst),
    .in_vld(v8), .in_rdy(rdy8),
    .A(a8), .B(b8), .sgn(s8),
    .out_vld(ov8), .out_rdy(ordy8),
    .Q(q8), .R(rr8), .dz(dz8), .ovf(of8)
  );

  div_iter #(.BITS(32)) u_d32 (
    .clk(clk), .rst(rst),
    .in_vld(v32), .in_rdy(rdy32),
    .A(a32), .B(b32), .sgn(s32),
    .out_vld(ov32), .out_rdy(ordy32),
    .Q(q32), .R(rr32), .dz(dz32), .ovf(of32)
  );

  // Reference: plain integer division with SV truncating semantics.
  function automatic void model(
    input  int          bits,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        s,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        z,
    output logic        o
  );
    longint mask, mn, sa, sb;
    mask = (longint'(1) << bits) - 1;
    mn   = longint'(1) << (bits - 1);
    z = 1'b0;
    o = 1'b0;
    if (b == 0) begin
      q = 32'(mask);
      r = a;
      z = 1'b1;
    end else if (s && a == mn && b == mask) begin
      q = a;
      r = 0;
      o = 1'b1;
    end else begin
      sa = a;
      sb = b;
      if (s && sa >= mn) sa = sa - (longint'(1) << bits);
      if (s && sb >= mn) sb = sb - (longint'(1) << bits);
      q = 32'((sa / sb) & mask);
      r = 32'((sa % sb) & mask);
    end
  endfunction

  task automatic run8(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       s,
    output logic [7:0] q,
    output logic [7:0] r,
    output logic       z,
    output logic       o,
    output int         lat
  );
    int n;
    @(negedge clk);
    a8 = a; b8 = b; s8 = s; v8 = 1'b1;
    n = 0;
    while (!rdy8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    v8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    s8 = 1'($urandom);
    lat = 0;
    while (!ov8 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!ov8) lat = -1;
    q = q8; r = rr8; z = dz8; o = of8;
  endtask

  task automatic ack8();
    @(negedge clk);
    ordy8 = 1'b1;
    @(posedge clk);
    #1;
    ordy8 = 1'b0;
  endtask

  task automatic run32(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        s,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        z,
    output logic        o,
    output int          lat
  );
    int n;
    @(negedge clk);
    a32 = a; b32 = b; s32 = s; v32 = 1'b1;
    n = 0;
    while (!rdy32 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    v32 = 1'b0;
    a32 = $urandom;
    b32 = $urandom;
    lat = 0;
    while (!ov32 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!ov32) lat = -1;
    q = q32; r = rr32; z = dz32; o = of32;
    @(negedge clk);
    ordy32 = 1'b1;
    @(posedge clk);
    #1;
    ordy32 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({rdy8, ov8, q8, rr8, dz8, of8} !== {2'b10, 16'h0, 2'b00}) begin
      $display("FAIL reset8 got %b/%b %h %h %b%b want 1/0 00 00 00",
               rdy8, ov8, q8, rr8, dz8, of8);
      errors++;
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rdy32, ov32, q32, rr32, dz32, of32} !== {2'b10, 64'h0, 2'b00}) begin
      $display("FAIL reset32 got %b/%b %h %h %b%b want 1/0 0 0 00",
               rdy32, ov32, q32, rr32, dz32, of32);
      errors++;
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [8] = '{8'd100, 8'hF9, 8'hF9, 8'h05,
                           8'h05, 8'h80, 8'h80, 8'h7F};
    logic [7:0] tb [8] = '{8'd7, 8'h02, 8'h02, 8'h00,
                           8'h00, 8'hFF, 8'hFF, 8'hFF};
    logic       ts [8] = '{0, 1, 0, 0, 1, 1, 0, 1};
    logic [7:0] tq [8] = '{8'd14, 8'hFD, 8'd124, 8'hFF,
                           8'hFF, 8'h80, 8'h00, 8'h81};
    logic [7:0] tr [8] = '{8'd2, 8'hFF, 8'd1, 8'h05,
                           8'h05, 8'h00, 8'h80, 8'h00};
    logic [1:0] tf [8] = '{2'b00, 2'b00, 2'b00, 2'b10,
                           2'b10, 2'b01, 2'b00, 2'b00};
    int         tl [8] = '{9, 9, 9, 0, 0, 0, 9, 9};
    logic [7:0] q, r;
    logic       z, o;
    int         lat;
    for (int i = 0; i < 8; i++) begin
      run8(ta[i], tb[i], ts[i], q, r, z, o, lat);
      checks++;
      if ({q, r, z, o} !== {tq[i], tr[i], tf[i]} || lat != tl[i]) begin
        $display("FAIL dir%0d got q=%h r=%h f=%b%b lat=%0d want %h %h %b %0d",
                 i, q, r, z, o, lat, tq[i], tr[i], tf[i], tl[i]);
        errors++;
      end
      ack8();
      checks++;
      if ({ov8, rdy8, dz8, of8} !== 4'b0100) begin
        $display("FAIL dir%0d_ack got vld=%b rdy=%b f=%b%b want 0 1 00",
                 i, ov8, rdy8, dz8, of8);
        errors++;
      end
    end
  endtask

  task automatic test_random8();
    logic [7:0]  a, b, q, r;
    logic        s, z, o, ez, eo;
    logic [31:0] eq, er;
    int          lat, el, sel;
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 8'h00;
      if (sel == 1) begin
        a = 8'h80; b = 8'hFF; s = 1'b1;
      end
      model(8, {24'h0, a}, {24'h0, b}, s, eq, er, ez, eo);
      el = (ez | eo) ? 0 : 9;
      run8(a, b, s, q, r, z, o, lat);
      checks++;
      if ({q, r, z, o} !== {eq[7:0], er[7:0], ez, eo} || lat != el) begin
        $display("FAIL rnd8 %h/%h s=%b got %h %h %b%b lat=%0d want %h %h %b%b %0d",
                 a, b, s, q, r, z, o, lat, eq[7:0], er[7:0], ez, eo, el);
        errors++;
      end
      ack8();
    end
  endtask

  task automatic test_wide();
    logic [31:0] a, b, q, r, eq, er;
    logic        s, z, o, ez, eo;
    int          lat, el;
    run32(32'h8000_0000, 32'd3, 1'b1, q, r, z, o, lat);
    checks++;
    if ({q, r, z, o} !== {32'hD555_5556, 32'hFFFF_FFFE, 2'b00} || lat != 33) begin
      $display("FAIL wide_min3 got %h %h %b%b lat=%0d want d5555556 fffffffe 00 33",
               q, r, z, o, lat);
      errors++;
    end
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = (i % 4 == 3) ? 32'($urandom_range(1, 300)) : $urandom;
      s = 1'($urandom);
      if (i == 5) b = 0;
      model(32, a, b, s, eq, er, ez, eo);
      el = (ez | eo) ? 0 : 33;
      run32(a, b, s, q, r, z, o, lat);
      checks++;
      if ({q, r, z, o} !== {eq, er, ez, eo} || lat != el) begin
        $display("FAIL rnd32 %h/%h s=%b got %h %h %b%b lat=%0d want %h %h %b%b %0d",
                 a, b, s, q, r, z, o, lat, eq, er, ez, eo, el);
        errors++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  ta [2] = '{8'd200, 8'd9};
    logic [7:0]  tb [2] = '{8'd13, 8'd0};
    logic [7:0]  q, r;
    logic        z, o, ez, eo;
    logic [31:0] eq, er;
    int          lat;
    for (int k = 0; k < 2; k++) begin
      model(8, {24'h0, ta[k]}, {24'h0, tb[k]}, 1'b0, eq, er, ez, eo);
      run8(ta[k], tb[k], 1'b0, q, r, z, o, lat);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        checks++;
        if ({ov8, rdy8, q8, rr8, dz8, of8} !==
            {2'b10, eq[7:0], er[7:0], ez, eo}) begin
          $display("FAIL hold%0d_%0d got vld=%b rdy=%b %h %h %b%b want 1 0 %h %h %b%b",
                   k, c, ov8, rdy8, q8, rr8, dz8, of8, eq[7:0], er[7:0], ez, eo);
          errors++;
        end
      end
      ack8();
      checks++;
      if ({ov8, rdy8, q8, rr8, dz8, of8} !==
          {2'b01, eq[7:0], er[7:0], 2'b00}) begin
        $display("FAIL release%0d got vld=%b rdy=%b %h %h %b%b want 0 1 %h %h 00",
                 k, ov8, rdy8, q8, rr8, dz8, of8, eq[7:0], er[7:0]);
        errors++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q, r;
    logic       z, o;
    int         lat;
    @(negedge clk);
    a8 = 8'hF9; b8 = 8'h02; s8 = 1'b1; v8 = 1'b1;
    @(posedge clk);
    #1;
    v8 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ov8, rdy8, q8, rr8, dz8, of8} !== {2'b01, 16'h0, 2'b00}) begin
      $display("FAIL rst_mid got vld=%b rdy=%b %h %h %b%b want 0 1 00 00 00",
               ov8, rdy8, q8, rr8, dz8, of8);
      errors++;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run8(8'd100, 8'd7, 1'b0, q, r, z, o, lat);
    checks++;
    if ({q, r, z, o} !== {8'd14, 8'd2, 2'b00} || lat != 9) begin
      $display("FAIL post_rst got %h %h %b%b lat=%0d want 0e 02 00 9",
               q, r, z, o, lat);
      errors++;
    end
    ack8();
    run8(8'd100, 8'd7, 1'b1, q, r, z, o, lat);
    checks++;
    if ({q, r, z, o} !== {8'd14, 8'd2, 2'b00} || lat != 9) begin
      $display("FAIL post_rst_sgn got %h %h %b%b lat=%0d want 0e 02 00 9",
               q, r, z, o, lat);
      errors++;
    end
    ack8();
  endtask

  task automatic test_back_to_back();
    int acc [$];
    int both;
    int bad;
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd7; s8 = 1'b0;
    v8 = 1'b1; ordy8 = 1'b1;
    both = 0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (rdy8 && ov8) both++;
      if (rdy8) acc.push_back(c);
      if (ov8 && (q8 !== 8'd14 || rr8 !== 8'd2)) bad++;
      @(negedge clk);
    end
    v8 = 1'b0;
    repeat (15) @(negedge clk);
    ordy8 = 1'b0;
    checks++;
    if (both != 0 || bad != 0 || acc.size() < 3) begin
      $display("FAIL b2b got overlap=%0d badres=%0d accepts=%0d want 0 0 >=3",
               both, bad, acc.size());
      errors++;
    end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 11) begin
        $display("FAIL b2b_gap%0d got %0d want 11", i, acc[i] - acc[i-1]);
        errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random8();
    test_wide();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
